// File: rtl/divun_pkg.sv
// Shared parameters and types for the iterative unsigned divider.
package divun_pkg;

    localparam int WIDTH          = 32;
    localparam int BITS_PER_CYCLE = 4;
    localparam int ITER           = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W          = $clog2(ITER);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

endpackage

// File: rtl/divun_step.sv
// One radix-2 restoring division step: shift, trial subtract, restore or keep.
module divun_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           borrow;

    // The partial remainder always stays below the divisor (and below 2^(WIDTH-1)
    // before the shift when the divisor is zero), so the top bit of the
    // WIDTH+1-bit difference is exactly the borrow.
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        trial   = shifted - {1'b0, div_i};
        borrow  = trial[WIDTH];
        rem_o   = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], ~borrow};
    end

endmodule

// File: rtl/divun_32.sv
// Iterative 32-bit unsigned divider, four quotient bits retired per clock.
//
// state | meaning
// IDLE  | waiting for enable; captures operands when enable=1
// CALC  | running chained restoring steps; loads outputs when counter = ITER-1
module divun_32 import divun_pkg::*; #(
    parameter int WIDTH          = divun_pkg::WIDTH,
    parameter int BITS_PER_CYCLE = divun_pkg::BITS_PER_CYCLE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor0,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int LAST = WIDTH / BITS_PER_CYCLE - 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             last_iter;

    logic [WIDTH-1:0] rem_chain [0:BITS_PER_CYCLE];
    logic [WIDTH-1:0] quo_chain [0:BITS_PER_CYCLE];

    assign rem_chain[0] = rem_q;
    assign quo_chain[0] = quo_q;

    // Chain of single-bit restoring steps evaluated MSB first within one cycle.
    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        divun_step #(.WIDTH(WIDTH)) u_step (
            .rem_i (rem_chain[g]),
            .quo_i (quo_chain[g]),
            .div_i (div_q),
            .rem_o (rem_chain[g+1]),
            .quo_o (quo_chain[g+1])
        );
    end

    assign last_iter = (cnt_q == CNT_W'(LAST));

    // State, working and output registers; synchronous reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            div_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            div_q       <= div_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    // Next-state: start on enable, return to IDLE after the final iteration.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = CALC;
            CALC:    if (last_iter) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath control: operand capture, per-cycle step advance, result load.
    always_comb begin
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        div_d       = div_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    quo_d = dividend;
                    div_d = divisor0;
                    rem_d = '0;
                    cnt_d = '0;
                end
            end
            CALC: begin
                rem_d = rem_chain[BITS_PER_CYCLE];
                quo_d = quo_chain[BITS_PER_CYCLE];
                cnt_d = cnt_q + 1'b1;
                if (last_iter) begin
                    quotient_d  = quo_chain[BITS_PER_CYCLE];
                    remainder_d = rem_chain[BITS_PER_CYCLE];
                end
            end
            default: ;
        endcase
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule

// File: tb/tb_divun_32.sv
// Self-checking bench for divun_32: directed corner cases plus random operands
// compared against plain integer division.
module tb_divun_32;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] dividend;
    logic [31:0] divisor0;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int errors = 0;
    int checks = 0;

    logic [31:0] prev_q = '0;
    logic [31:0] prev_r = '0;

    always #5 clk = ~clk;

    divun_32 dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .dividend  (dividend),
        .divisor0  (divisor0),
        .quotient  (quotient),
        .remainder (remainder)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Caller is at posedge+1 with the DUT idle. Operands are scrambled right after
    // capture; drop_at>0 lowers enable after that many compute edges.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input string tag, input int drop_at);
        logic [31:0] eq, er;
        ref_div(a, b, eq, er);
        dividend = a;
        divisor0 = b;
        enable   = 1'b1;
        @(posedge clk); #1;
        dividend = $urandom;
        divisor0 = $urandom;
        for (int i = 1; i <= 7; i++) begin
            @(posedge clk); #1;
            if (i == drop_at) enable = 1'b0;
        end
        check({tag, "_hold_q"}, quotient, prev_q);
        check({tag, "_hold_r"}, remainder, prev_r);
        @(posedge clk); #1;
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        prev_q = eq;
        prev_r = er;
    endtask

    initial begin
        logic [31:0] a, b;

        reset    = 1'b1;
        enable   = 1'b0;
        dividend = 32'd0;
        divisor0 = 32'd0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_q", quotient, 32'd0);
        check("reset_r", remainder, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_q", quotient, 32'd0);
        check("idle_r", remainder, 32'd0);

        // Back-to-back with enable held high.
        run_div(32'd183, 32'd14, "d183_14", 0);
        run_div(32'd115, 32'd1, "d115_1", 0);
        run_div(32'd153, 32'd1, "d153_1", 0);
        run_div(32'd13, 32'd0, "d13_0", 0);
        run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, "dmax_max", 0);
        run_div(32'hFFFF_FFFF, 32'd2, "dmax_2", 0);
        run_div(32'd5, 32'd7, "d5_7", 0);

        enable = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("hold_q", quotient, prev_q);
        check("hold_r", remainder, prev_r);

        // enable dropped mid-computation still completes.
        run_div(32'd1000, 32'd7, "drop_en", 2);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset at E4 discards the in-flight division.
        dividend = 32'd999;
        divisor0 = 32'd10;
        enable   = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_mid_q", quotient, 32'd0);
        check("rst_mid_r", remainder, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("rst_noresult_q", quotient, 32'd0);
        check("rst_noresult_r", remainder, 32'd0);
        prev_q = '0;
        prev_r = '0;

        // Random operands, back-to-back.
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = $urandom;
                1: b = $urandom >> $urandom_range(1, 31);
                2: b = $urandom_range(1, 15);
                default: b = (n % 10 == 0) ? 32'd0 : ($urandom & 32'h0000_FFFF);
            endcase
            if (n % 7 == 3) a = b * $urandom_range(0, 50) + $urandom_range(0, 3);
            run_div(a, b, "rand", 0);
        end
        enable = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
